// File: rtl/reg_write_buffer_if.sv
// ---------------------------------------------------------------------------
// reg_write_buffer_if
// Producer-side write offer into the register write buffer.
//   req_valid : producer offers a register write this cycle
//   req_sel   : destination register index of the offered write
//   req_dat   : data of the offered write
//   req_ready : buffer will accept the offer at the next rising edge
// Modports:
//   master : the producer (drives the offer, observes req_ready)
//   slave  : the buffer (observes the offer, drives req_ready)
// ---------------------------------------------------------------------------
interface reg_write_buffer_if;
    logic        req_valid;
    logic [4:0]  req_sel;
    logic [31:0] req_dat;
    logic        req_ready;

    modport master (
        output req_valid,
        output req_sel,
        output req_dat,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        input  req_dat,
        output req_ready
    );
endinterface

// File: rtl/reg_write_buffer.sv
// ---------------------------------------------------------------------------
// reg_write_buffer
// In-order buffer of pending register-file writes. Accepted writes queue up
// and drain one per cycle into the register-file write port whenever that
// port is not held. Two read ports are corrected for writes still pending,
// so readers always see the youngest pending value for a register.
// Ports:
//   CLK, nRST          : clock (rising edge) and asynchronous active-low reset
//   req (slave)        : write offer handshake (valid/sel/dat/ready)
//   hold               : register-file write port busy; no draining
//   WEN, wsel, wdat    : write port toward the register file (head entry)
//   rsel1/2, rf_rdat1/2: read indices and raw register-file read data
//   rdat1/2            : read data with pending writes forwarded
//   count              : number of valid pending entries
// Parameter:
//   DEPTH              : number of entries, power of two in 2..16
// ---------------------------------------------------------------------------
module reg_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    reg_write_buffer_if.slave        req,
    input  logic                     hold,
    output logic                     WEN,
    output logic [4:0]               wsel,
    output logic [31:0]              wdat,
    input  logic [4:0]               rsel1,
    input  logic [4:0]               rsel2,
    input  logic [31:0]              rf_rdat1,
    input  logic [31:0]              rf_rdat2,
    output logic [31:0]              rdat1,
    output logic [31:0]              rdat2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] count_reg, count_next;
    logic [AW-1:0] head_reg,  head_next;
    logic [AW-1:0] tail_reg,  tail_next;
    logic [4:0]    sel_reg [DEPTH];
    logic [31:0]   dat_reg [DEPTH];

    logic          ready;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic [DEPTH-1:0] entry_valid;

    // Ready looks only at the current occupancy, never at a same-cycle pop,
    // so the producer never sees a combinational path through hold.
    assign ready     = (count_reg < CW'(DEPTH));
    assign not_empty = (count_reg != '0);
    assign req.req_ready = ready;

    // Writes to register 0 are handshaken normally but never stored.
    assign push = req.req_valid & ready & (req.req_sel != 5'd0);
    assign pop  = not_empty & ~hold;

    assign WEN   = pop;
    assign wsel  = not_empty ? sel_reg[head_reg] : 5'd0;
    assign wdat  = not_empty ? dat_reg[head_reg] : 32'd0;
    assign count = count_reg;

    always_comb begin
        count_next = count_reg + CW'(push) - CW'(pop);
        head_next  = pop  ? head_reg + AW'(1) : head_reg;
        tail_next  = push ? tail_reg + AW'(1) : tail_reg;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sel_reg[i] <= '0;
                dat_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            if (push) begin
                sel_reg[tail_reg] <= req.req_sel;
                dat_reg[tail_reg] <= req.req_dat;
            end
        end
    end

    // A slot holds a pending write when its distance from the head (modulo
    // DEPTH) is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic [AW-1:0] age;
            assign age             = AW'(gi) - head_reg;
            assign entry_valid[gi] = ({1'b0, age} < count_reg);
        end
    endgenerate

    // Read-port forwarding. Slots are scanned oldest to youngest so the last
    // match, i.e. the youngest pending write, wins. The current offer is not
    // stored yet and therefore never forwarded.
    logic [4:0]  rsel_a    [2];
    logic [31:0] rf_rdat_a [2];
    logic [31:0] rdat_a    [2];

    assign rsel_a[0]    = rsel1;
    assign rsel_a[1]    = rsel2;
    assign rf_rdat_a[0] = rf_rdat1;
    assign rf_rdat_a[1] = rf_rdat2;
    assign rdat1        = rdat_a[0];
    assign rdat2        = rdat_a[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            logic [AW-1:0] scan_idx;
            logic [31:0]   hit_dat;

            always_comb begin
                hit_dat  = rf_rdat_a[gi];
                scan_idx = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    scan_idx = head_reg + AW'(k);
                    if (entry_valid[scan_idx] && (sel_reg[scan_idx] == rsel_a[gi]))
                        hit_dat = dat_reg[scan_idx];
                end
            end

            assign rdat_a[gi] = (rsel_a[gi] == 5'd0) ? 32'd0 : hit_dat;
        end
    endgenerate

endmodule

// File: doc/reg_write_buffer.md
REG_WRITE_BUFFER -- requirements
Module: reg_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pending write entries (power of two, 2..16).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  producer offers a register write this cycle.
REQ-005 SHALL have port req_sel  input  5  destination register index of the offered write.
REQ-006 SHALL have port req_dat  input  32  data of the offered write.
REQ-007 SHALL have port req_ready  output  1  buffer accepts the offered write at the next edge.
REQ-008 SHALL have port hold  input  1  register-file write port unavailable; suppress draining.
REQ-009 SHALL have port WEN  output  1  write enable to the register file write port.
REQ-010 SHALL have port wsel  output  5  write index to the register file.
REQ-011 SHALL have port wdat  output  32  write data to the register file.
REQ-012 SHALL have ports rsel1, rsel2  input  5 each  read indices presented to the register file.
REQ-013 SHALL have ports rf_rdat1, rf_rdat2  input  32 each  raw read data returned by the register file.
REQ-014 SHALL have ports rdat1, rdat2  output  32 each  read data corrected for pending writes.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of valid pending entries.

Function
REQ-016 SHALL hold writes in an in-order FIFO of DEPTH entries (sel, dat), head = oldest.
REQ-017 SHALL drive req_ready = 1 iff count < DEPTH; req_ready SHALL NOT depend on same-cycle drain.
REQ-018 SHALL accept a write at an edge iff req_valid & req_ready; an accepted write with req_sel = 0 SHALL be discarded (not enqueued, count unchanged).
REQ-019 SHALL drive WEN = (count != 0) & ~hold combinationally; wsel/wdat SHALL equal head entry when count != 0, else 0.
REQ-020 SHALL pop the head at an edge iff WEN = 1 at that edge.
REQ-021 SHALL make a write accepted at edge N visible on WEN no earlier than the cycle following edge N (no same-cycle pass-through).
REQ-022 SHALL update count as count + push - pop; simultaneous push and pop SHALL leave count unchanged and both SHALL take effect.
REQ-023 SHALL wrap head and tail pointers modulo DEPTH with no lost or duplicated entries.
REQ-024 SHALL drive rdatN = 0 when rselN = 0.
REQ-025 SHALL, for rselN != 0, drive rdatN = dat of the youngest pending entry whose sel = rselN, else rf_rdatN; purely combinational.
REQ-026 SHALL NOT bypass req_dat of the not-yet-accepted current offer.
REQ-027 SHALL keep all entries, ordering and count unchanged while hold = 1, except for pushes.
REQ-028 SHALL ignore req_sel/req_dat when req_valid = 0.

Reset
REQ-029 SHALL, while nRST = 0, clear count, head and tail pointers and all entry fields to 0 asynchronously.
REQ-030 SHALL drive during reset: req_ready = 1, WEN = 0, wsel = 0, wdat = 0, count = 0, rdatN = 0 if rselN = 0 else rf_rdatN.
REQ-031 SHALL discard all pending writes if reset asserts mid-operation; none are written after release.

Verification
REQ-032 SHALL pass: push (sel 5, 0xDEADBEEF), hold = 0 -> next cycle WEN = 1, wsel = 5, wdat = 0xDEADBEEF; following cycle count = 0, WEN = 0.
REQ-033 SHALL pass: hold = 1, push 4 writes (sel 1..4) -> count = 4, req_ready = 0, 5th offer not accepted; release hold -> WEN asserted four consecutive cycles, wsel 1,2,3,4 in order.
REQ-034 SHALL pass: pending (sel 7, 0x11) then (sel 7, 0x22), rsel1 = 7, rf_rdat1 = 0x99 -> rdat1 = 0x22; rsel2 = 8 -> rdat2 = rf_rdat2.
REQ-035 SHALL pass: push sel 0 data 0xFFFFFFFF -> count stays 0, WEN never asserts; rsel1 = 0 -> rdat1 = 0.
REQ-036 SHALL pass: full buffer, hold = 0, req_valid = 1 -> req_ready = 0 that cycle, one pop, count = 3; next cycle push accepted, count remains 3; 12 more pushes drain in order across pointer wrap.
REQ-037 SHALL pass: 3 pending entries, nRST pulsed low mid-cycle -> count = 0 and WEN = 0 immediately, no pending write appears after release.
